// File: rtl/shift_arbiter_pkg.sv
// Shared widths, shift encodings and the issue-register payload for shift_arbiter.
package shift_arbiter_pkg;

    localparam int unsigned SH_W  = 64;
    localparam int unsigned AMT_W = 6;

    localparam logic DIR_LEFT   = 1'b0;
    localparam logic DIR_RIGHT  = 1'b1;
    localparam logic TYPE_LOGIC = 1'b0;
    localparam logic TYPE_ARITH = 1'b1;

    // One shift operation as captured from a requester.
    typedef struct packed {
        logic [SH_W-1:0]  d;
        logic [AMT_W-1:0] amt;
        logic             dir;
        logic             typ;
    } shift_op_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/result bus of shift_arbiter.
//   req_*  : per-requester operands and valid/ready handshake (requester i in slice i)
//   res_*  : single tagged result channel, valid/ready
//   busy   : pipeline holds at least one operation
// master = requester/consumer side, slave = shift_arbiter.
interface shift_arbiter_if
    import shift_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [SH_W*N_REQ-1:0]  req_d_in;
    logic [AMT_W*N_REQ-1:0] req_sh_amt;
    logic [N_REQ-1:0]       req_dir;
    logic [N_REQ-1:0]       req_type;
    logic                   res_valid;
    logic                   res_ready;
    logic [SH_W-1:0]        res_d_out;
    logic                   res_z;
    logic [ID_W-1:0]        res_id;
    logic                   busy;

    modport master (
        output req_valid, req_d_in, req_sh_amt, req_dir, req_type, res_ready,
        input  req_ready, res_valid, res_d_out, res_z, res_id, busy
    );

    modport slave (
        input  req_valid, req_d_in, req_sh_amt, req_dir, req_type, res_ready,
        output req_ready, res_valid, res_d_out, res_z, res_id, busy
    );
endinterface

// File: rtl/Barrel_shifter_64_bit.sv
// Combinational 64-bit barrel shifter with zero flag.
//   d_in, sh_amt : operand and shift amount
//   dir          : 0 left, 1 right
//   sh_type      : 0 logical, 1 arithmetic (right shifts only)
//   d_out, zero  : shifted result and d_out == 0
module Barrel_shifter_64_bit
    import shift_arbiter_pkg::*;
(
    input  logic [SH_W-1:0]  d_in,
    input  logic [AMT_W-1:0] sh_amt,
    input  logic             dir,
    input  logic             sh_type,
    output logic [SH_W-1:0]  d_out,
    output logic             zero
);
    always_comb begin
        d_out = d_in;
        if (dir == DIR_LEFT) begin
            d_out = d_in << sh_amt;
        end else if (sh_type == TYPE_ARITH) begin
            d_out = SH_W'($signed(d_in) >>> sh_amt);
        end else begin
            d_out = d_in >> sh_amt;
        end
        zero = (d_out == '0);
    end
endmodule

// File: rtl/shift_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
//   req     : request vector
//   ptr     : highest-priority index this cycle
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : binary index of the grant
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx
);
    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = ID_W'((32'(ptr) + i) % N_REQ);
            if (!found && req[idx]) begin
                found     = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_idx   = idx;
            end
        end
    end
endmodule

// File: rtl/shift_arbiter.sv
// Shares one barrel shifter between N_REQ requesters through a two-stage
// pipeline (issue register -> shifter -> result register), tagging each result
// with the owning requester index.
//   clk, rst : clock and synchronous active-high reset
//   bus      : request/result channels (see shift_arbiter_if)
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    shift_arbiter_if.slave   bus
);
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W-1:0]  ptr;
    logic             v1, v2;
    logic             adv1, adv2, hs;
    shift_op_t        iss_op, op_c;
    logic [ID_W-1:0]  iss_id;
    logic [SH_W-1:0]  sh_out;
    logic             sh_zero;
    logic [SH_W-1:0]  res_d;
    logic             res_z;
    logic [ID_W-1:0]  res_id;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Pipeline advance conditions; a handshake needs the issue register to move.
    always_comb begin
        adv2 = !v2 || bus.res_ready;
        adv1 = !v1 || adv2;
        hs   = !rst && adv1 && (|bus.req_valid);
    end

    assign bus.req_ready = hs ? gnt : '0;

    // Select the winning requester's operands.
    always_comb begin
        op_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                op_c.d   = bus.req_d_in[i*SH_W +: SH_W];
                op_c.amt = bus.req_sh_amt[i*AMT_W +: AMT_W];
                op_c.dir = bus.req_dir[i];
                op_c.typ = bus.req_type[i];
            end
        end
    end

    Barrel_shifter_64_bit u_shifter (
        .d_in    (iss_op.d),
        .sh_amt  (iss_op.amt),
        .dir     (iss_op.dir),
        .sh_type (iss_op.typ),
        .d_out   (sh_out),
        .zero    (sh_zero)
    );

    // Issue and result registers plus round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            ptr    <= '0;
            iss_op <= '0;
            iss_id <= '0;
            res_d  <= '0;
            res_z  <= 1'b0;
            res_id <= '0;
        end else begin
            if (hs) begin
                iss_op <= op_c;
                iss_id <= gnt_idx;
                ptr    <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
                v1     <= 1'b1;
            end else if (adv2) begin
                v1     <= 1'b0;
            end
            if (adv2) begin
                v2 <= v1;
                // Keep the last result visible when the issue slot was empty.
                if (v1) begin
                    res_d  <= sh_out;
                    res_z  <= sh_zero;
                    res_id <= iss_id;
                end
            end
        end
    end

    assign bus.res_valid = v2;
    assign bus.res_d_out = res_d;
    assign bus.res_z     = res_z;
    assign bus.res_id    = res_id;
    assign bus.busy      = v1 | v2;
endmodule
